// File: rtl/riscv_pkg.sv
// Shared RV32M multiply/divide types: operation codes (RV32M funct3),
// sequencer states, default datapath width and small opcode decoders.
package riscv_pkg;

  localparam int BUS_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  // Divide-class operations (quotient or remainder)
  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  // rs1 is interpreted as two's complement
  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is interpreted as two's complement
  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration on magnitudes: either a shift-add
// multiply step on the double-width product, or a restoring shift-subtract
// divide step on the remainder/quotient pair. The registers that the
// selected operation does not use pass through unchanged.
module muldiv_step
  import riscv_pkg::*;
#(
  parameter int XLEN = BUS_WIDTH
) (
  input  logic                i_is_div,
  input  logic [2*XLEN-1:0]   i_prod,
  input  logic [XLEN-1:0]     i_opb,
  input  logic [XLEN:0]       i_rem,
  input  logic [XLEN-1:0]     i_quo,
  output logic [2*XLEN-1:0]   o_prod,
  output logic [XLEN:0]       o_rem,
  output logic [XLEN-1:0]     o_quo
);

  logic [XLEN:0]   w_sum;
  logic [XLEN+1:0] w_shift;
  logic [XLEN+1:0] w_diff;

  // Single iteration: add-and-shift for multiply, trial subtract for divide
  always_comb begin
    w_sum   = {1'b0, i_prod[2*XLEN-1:XLEN]} +
              (i_prod[0] ? {1'b0, i_opb} : {(XLEN+1){1'b0}});
    w_shift = {i_rem, i_quo[XLEN-1]};
    w_diff  = w_shift - {2'b00, i_opb};
    o_prod  = i_prod;
    o_rem   = i_rem;
    o_quo   = i_quo;
    if (i_is_div) begin
      if (!w_diff[XLEN+1]) begin
        o_rem = w_diff[XLEN:0];
        o_quo = {i_quo[XLEN-2:0], 1'b1};
      end else begin
        o_rem = w_shift[XLEN:0];
        o_quo = {i_quo[XLEN-2:0], 1'b0};
      end
    end else begin
      o_prod = {w_sum, i_prod[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage. Operands are
// reduced to magnitudes on accept, iterated one bit per cycle, sign-corrected
// in FIX and published from registered outputs in DONE until consumed.
module iter_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN      = BUS_WIDTH,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            div_zero_o,
  output logic            over_under_flow
);

  localparam int CW = $clog2(XLEN);

  muldiv_state_e     r_state;
  muldiv_op_e        r_op;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_opb;
  logic [XLEN:0]     r_rem;
  logic [XLEN-1:0]   r_quo;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_b_zero;
  logic              r_min_neg1;
  logic [XLEN-1:0]   r_res;
  logic              r_dz;
  logic              r_ovf;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_result;
  logic              r_div_zero;
  logic              r_ovf_out;

  // Accept-side decode
  muldiv_op_e        w_op;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_b_zero;
  logic              w_min_neg1;
  logic              w_fast;

  // Iteration step outputs
  logic [2*XLEN-1:0] w_prod_n;
  logic [XLEN:0]     w_rem_n;
  logic [XLEN-1:0]   w_quo_n;

  // Fix-up values
  logic [2*XLEN-1:0] w_prod_c;
  logic [XLEN-1:0]   w_quo_c;
  logic [XLEN-1:0]   w_rem_c;
  logic [XLEN-1:0]   w_fix_res;
  logic              w_fix_dz;
  logic              w_fix_ovf;

  assign in_ready_o      = r_in_ready;
  assign out_valid_o     = r_out_valid;
  assign result_o        = r_result;
  assign div_zero_o      = r_div_zero;
  assign over_under_flow = r_ovf_out;

  // Operand magnitudes and special-case detection for a new request;
  // the magnitude of the most negative value wraps to itself and is then
  // read as the unsigned 2^(XLEN-1)
  always_comb begin
    w_op       = muldiv_op_e'(op_i);
    w_sa       = op_a_signed(w_op) & a_i[XLEN-1];
    w_sb       = op_b_signed(w_op) & b_i[XLEN-1];
    w_abs_a    = w_sa ? ({XLEN{1'b0}} - a_i) : a_i;
    w_abs_b    = w_sb ? ({XLEN{1'b0}} - b_i) : b_i;
    w_b_zero   = (b_i == {XLEN{1'b0}});
    w_min_neg1 = op_is_div(w_op) & op_b_signed(w_op) &
                 (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == {XLEN{1'b1}});
    w_fast     = FAST_ZERO & op_is_div(w_op) & (w_b_zero | w_min_neg1);
  end

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .i_is_div (op_is_div(r_op)),
    .i_prod   (r_prod),
    .i_opb    (r_opb),
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .o_prod   (w_prod_n),
    .o_rem    (w_rem_n),
    .o_quo    (w_quo_n)
  );

  // Sign correction, result selection and flag generation for the FIX cycle
  always_comb begin
    w_prod_c = r_neg_q ? ({(2*XLEN){1'b0}} - r_prod) : r_prod;
    if (r_b_zero) begin
      w_quo_c = {XLEN{1'b1}};
    end else if (r_neg_q) begin
      w_quo_c = {XLEN{1'b0}} - r_quo;
    end else begin
      w_quo_c = r_quo;
    end
    w_rem_c = r_neg_r ? ({XLEN{1'b0}} - r_rem[XLEN-1:0]) : r_rem[XLEN-1:0];
    case (r_op)
      MD_MUL:                      w_fix_res = w_prod_c[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix_res = w_prod_c[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             w_fix_res = w_quo_c;
      MD_REM, MD_REMU:             w_fix_res = w_rem_c;
      default:                     w_fix_res = {XLEN{1'b0}};
    endcase
    if (op_is_div(r_op)) begin
      w_fix_dz  = r_b_zero;
      w_fix_ovf = r_min_neg1;
    end else begin
      w_fix_dz  = 1'b0;
      w_fix_ovf = (w_prod_c[2*XLEN-1:XLEN] != {XLEN{w_prod_c[XLEN-1]}});
    end
  end

  // Sequencer FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= MD_MUL;
      r_cnt       <= {CW{1'b0}};
      r_prod      <= {(2*XLEN){1'b0}};
      r_opb       <= {XLEN{1'b0}};
      r_rem       <= {(XLEN+1){1'b0}};
      r_quo       <= {XLEN{1'b0}};
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_b_zero    <= 1'b0;
      r_min_neg1  <= 1'b0;
      r_res       <= {XLEN{1'b0}};
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= {XLEN{1'b0}};
      r_div_zero  <= 1'b0;
      r_ovf_out   <= 1'b0;
    end else if (flush_i) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_op       <= w_op;
            r_cnt      <= CW'(XLEN-1);
            r_prod     <= {{XLEN{1'b0}}, w_abs_a};
            r_opb      <= w_abs_b;
            r_quo      <= w_abs_a;
            r_rem      <= (w_fast & w_b_zero) ? {1'b0, w_abs_a} : {(XLEN+1){1'b0}};
            r_neg_q    <= w_sa ^ w_sb;
            r_neg_r    <= w_sa;
            r_b_zero   <= w_b_zero;
            r_min_neg1 <= w_min_neg1;
            r_in_ready <= 1'b0;
            r_state    <= w_fast ? ST_FIX : ST_CALC;
          end
        end
        ST_CALC: begin
          r_prod <= w_prod_n;
          r_rem  <= w_rem_n;
          r_quo  <= w_quo_n;
          if (r_cnt == {CW{1'b0}}) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_FIX: begin
          r_res   <= w_fix_res;
          r_dz    <= w_fix_dz;
          r_ovf   <= w_fix_ovf;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_result    <= r_res;
            r_div_zero  <= r_dz;
            r_ovf_out   <= r_ovf;
          end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Self-checking bench for iter_muldiv_unit (XLEN=32, FAST_ZERO=1): directed
// vectors with hand-computed results, flush/reset/back-pressure scenarios and
// random operations, all checked against an arithmetic reference model.
module tb_iter_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        div_zero_o;
  logic        over_under_flow;

  iter_muldiv_unit #(.XLEN(32), .FAST_ZERO(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .op_i            (op_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .result_o        (result_o),
    .div_zero_o      (div_zero_o),
    .over_under_flow (over_under_flow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    logic        ovf;
    int          lat;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t cur;
  bit   exp_pending = 1'b0;

  // Reference: plain 64-bit / signed arithmetic straight from the RV32M rules
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] a64, b64, p;
    logic signed [31:0] sa, sb;
    bit sgn;
    e.dz = 1'b0; e.ovf = 1'b0; e.lat = 34;
    sa = a; sb = b;
    if (op < 3'd4) begin
      a64 = (op != OP_MULHU) ? {{32{a[31]}}, a} : {32'd0, a};
      b64 = (op == OP_MUL || op == OP_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
      p = a64 * b64;
      e.res = (op == OP_MUL) ? p[31:0] : p[63:32];
      e.ovf = (p[63:32] != {32{p[31]}});
    end else begin
      sgn = (op == OP_DIV || op == OP_REM);
      if (b == 32'd0) begin
        e.res = (op[1]) ? a : 32'hFFFF_FFFF;
        e.dz  = 1'b1;
        e.lat = 2;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.res = (op[1]) ? 32'd0 : 32'h8000_0000;
        e.ovf = 1'b1;
        e.lat = 2;
      end else if (sgn) begin
        e.res = (op[1]) ? 32'(sa % sb) : 32'(sa / sb);
      end else begin
        e.res = (op[1]) ? (a % b) : (a / b);
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Output monitor: whenever a result is presented it must match the model
  always @(negedge clk) begin
    if (rst_n && out_valid_o) begin
      n_cmp++;
      if (!exp_pending) begin
        n_err++;
        $display("FAIL spurious_valid: out_valid_o=1 with no op outstanding at %0t", $time);
      end else if ({result_o, div_zero_o, over_under_flow, in_ready_o} !==
                   {cur.res, cur.dz, cur.ovf, 1'b0}) begin
        n_err++;
        $display("FAIL result: got res=0x%08h dz=%0b ovf=%0b rdy=%0b, expected res=0x%08h dz=%0b ovf=%0b rdy=0 at %0t",
                 result_o, div_zero_o, over_under_flow, in_ready_o, cur.res, cur.dz, cur.ovf, $time);
      end
    end
  end

  task automatic accept_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output bit ok);
    int t;
    ok = 1'b0;
    t = 0;
    @(negedge clk);
    while (!in_ready_o && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready_o) begin
      check("in_ready_timeout", 32'(in_ready_o), 32'd1);
      return;
    end
    op_i = op; a_i = a; b_i = b; in_valid_i = 1'b1;
    cur = model(op, a, b);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    exp_pending = 1'b1;
    ok = 1'b1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit use_hand,
                       input logic [31:0] h_res, input logic h_dz, input logic h_ovf);
    bit ok;
    int lat;
    accept_op(op, a, b, ok);
    if (!ok) return;
    if (use_hand) begin
      check("hand_res", cur.res, h_res);
      check("hand_flags", {30'd0, cur.dz, cur.ovf}, {30'd0, h_dz, h_ovf});
    end
    lat = 0;
    while (!out_valid_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid_o) begin
      check("valid_timeout", 32'(out_valid_o), 32'd1);
      exp_pending = 1'b0;
      return;
    end
    check("latency", 32'(lat), 32'(cur.lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_rdy_valid", {30'd0, in_ready_o, out_valid_o}, 32'd1);
      check("hold_result", result_o, cur.res);
    end
    @(negedge clk);
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    exp_pending = 1'b0;
    check("after_consume", {30'd0, in_ready_o, out_valid_o}, 32'd2);
  endtask

  task automatic flush_after(input int d, input bit with_ready);
    repeat (d) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    out_ready_i = with_ready;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    exp_pending = 1'b0;
    check("after_flush", {30'd0, in_ready_o, out_valid_o}, 32'd2);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit ok;
    int t;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    #12;
    check("reset_state", {result_o[27:0], in_ready_o, out_valid_o, div_zero_o, over_under_flow}, 32'h0000_0008);
    check("reset_result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed expectations
    do_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 0, 1'b1, 32'hFFFF_FFEB, 1'b0, 1'b0);
    do_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 0, 1'b1, 32'h4000_0000, 1'b0, 1'b1);
    do_op(OP_MULHU,  32'h8000_0000, 32'h8000_0000, 0, 1'b1, 32'h4000_0000, 1'b0, 1'b1);
    do_op(OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 0, 1'b1, 32'hC000_0000, 1'b0, 1'b1);
    do_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         0, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(OP_DIVU,   32'd100,       32'd7,         0, 1'b1, 32'd14,        1'b0, 1'b0);
    do_op(OP_REMU,   32'd100,       32'd7,         0, 1'b1, 32'd2,         1'b0, 1'b0);
    do_op(OP_DIV,    32'd5,         32'd0,         0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(OP_REM,    32'd5,         32'd0,         0, 1'b1, 32'd5,         1'b1, 1'b0);
    do_op(OP_REM,    32'hFFFF_FFF9, 32'd0,         0, 1'b1, 32'hFFFF_FFF9, 1'b1, 1'b0);
    do_op(OP_DIVU,   32'd5,         32'd0,         0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    do_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'd0,         1'b0, 1'b1);
    do_op(OP_MUL,    32'd12345,     32'd678,       0, 1'b1, 32'd8369910,   1'b0, 1'b0);

    // Back-pressure: result and flags held for 10 cycles
    do_op(OP_MULH, 32'hFFFF_FFFF, 32'd3, 10, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Flush mid-CALC, then no valid must appear, then a normal op
    accept_op(OP_DIVU, 32'd100, 32'd7, ok);
    flush_after(10, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      check("flushed_no_valid", 32'(out_valid_o), 32'd0);
    end
    do_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b1, 32'd14, 1'b0, 1'b0);

    // Flush together with in_valid in IDLE: nothing is accepted
    @(negedge clk);
    op_i = OP_MUL; a_i = 32'd3; b_i = 32'd4; in_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0; flush_i = 1'b0;
    check("flush_beats_valid", {30'd0, in_ready_o, out_valid_o}, 32'd2);

    // Flush together with out_ready in DONE: dropped, not consumed
    accept_op(OP_MUL, 32'd3, 32'd4, ok);
    t = 0;
    while (!out_valid_o && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("valid_before_flush", 32'(out_valid_o), 32'd1);
    flush_after(0, 1'b1);

    // Asynchronous reset in the middle of CALC
    accept_op(OP_DIV, 32'd1000, 32'd3, ok);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_pending = 1'b0;
    check("reset_mid_calc", {28'd0, in_ready_o, out_valid_o, div_zero_o, over_under_flow}, 32'h8);
    check("reset_mid_result", result_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(in_ready_o), 32'd1);
    do_op(OP_DIV, 32'd1000, 32'd3, 0, 1'b1, 32'd333, 1'b0, 1'b0);

    // Random operations with random flush and back-pressure
    for (int n = 0; n < 600; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      if ($urandom_range(0, 9) == 0) begin
        accept_op(rop, ra, rb, ok);
        if (ok) flush_after($urandom_range(0, 40), 1'($urandom_range(0, 1)));
      end else begin
        do_op(rop, ra, rb, $urandom_range(0, 3), 1'b0, 32'd0, 1'b0, 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
